// File: rtl/ctrl_decode_md.sv
// ctrl_decode_md: registered ID->EX decoder for RV32I with optional RV32M.
// MUL/DIV/REM occupy EX for a fixed number of cycles. The sequencer requests
// a stall until the result is ready. Illegal encodings are replaced by a bubble.
module ctrl_decode_md #(
    parameter bit          EN_M       = 1'b1,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [6:0]  Op,
    input  logic [2:0]  Fn3,
    input  logic [6:0]  Fn7,
    input  logic        ValidD,
    input  logic        StallE,
    input  logic        FlushE,
    output logic [25:0] CtrlE,
    output logic        MdValidE,
    output logic [2:0]  MdOpE,
    output logic        MdBusy,
    output logic        MdDoneE,
    output logic        IllegalD
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    localparam logic [2:0] RW_NONE = 3'd0, RW_LB = 3'd1, RW_LH = 3'd2;
    localparam logic [2:0] RW_LW   = 3'd3, RW_LBU = 3'd4, RW_LHU = 3'd5;

    localparam logic [2:0] BR_NONE = 3'd0, BR_BEQ = 3'd1, BR_BNE = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3, BR_BLTU = 3'd4, BR_BGE = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    localparam logic [2:0] IMM_R = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;

    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_SRA = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd3, ALU_SUB = 4'd4, ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_OR  = 4'd6, ALU_AND = 4'd7, ALU_SLT = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9, ALU_LUI = 4'd10;

    localparam logic [1:0] SRC2_REG = 2'b00, SRC2_SHAMT = 2'b01, SRC2_IMM = 2'b10;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    // one-hot so busy/done are plain flop bits
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;

    logic       jal, jalr, mem_to_reg, load_npc, alu_src1;
    logic [2:0] reg_write, br_type, imm_type;
    logic [3:0] mem_write, alu_ctrl;
    logic [1:0] reg_read, alu_src2;
    logic       dec_bad, dec_md;
    logic [25:0] dec_ctrl;

    // combinational ID decode; every field defaults to the bubble value
    always_comb begin
        jal        = 1'b0;
        jalr       = 1'b0;
        reg_write  = RW_NONE;
        mem_to_reg = 1'b0;
        mem_write  = 4'b0000;
        load_npc   = 1'b0;
        reg_read   = 2'b00;
        br_type    = BR_NONE;
        alu_ctrl   = ALU_SLL;
        alu_src1   = 1'b0;
        alu_src2   = SRC2_REG;
        imm_type   = IMM_R;
        dec_bad    = 1'b0;
        dec_md     = 1'b0;
        case (Op)
            OPC_LUI: begin
                reg_write = RW_LW;
                alu_ctrl  = ALU_LUI;
                alu_src2  = SRC2_IMM;
                imm_type  = IMM_U;
            end
            OPC_AUIPC: begin
                reg_write = RW_LW;
                alu_ctrl  = ALU_ADD;
                alu_src1  = 1'b1;
                alu_src2  = SRC2_IMM;
                imm_type  = IMM_U;
            end
            OPC_JAL: begin
                jal       = 1'b1;
                reg_write = RW_LW;
                load_npc  = 1'b1;
                alu_ctrl  = ALU_ADD;
                alu_src1  = 1'b1;
                alu_src2  = SRC2_IMM;
                imm_type  = IMM_J;
            end
            OPC_JALR: begin
                jalr      = 1'b1;
                reg_write = RW_LW;
                load_npc  = 1'b1;
                reg_read  = 2'b10;
                alu_ctrl  = ALU_ADD;
                alu_src2  = SRC2_IMM;
                imm_type  = IMM_I;
            end
            OPC_BRANCH: begin
                reg_read = 2'b11;
                imm_type = IMM_B;
                case (Fn3)
                    3'b000:  br_type = BR_BEQ;
                    3'b001:  br_type = BR_BNE;
                    3'b100:  br_type = BR_BLT;
                    3'b101:  br_type = BR_BGE;
                    3'b110:  br_type = BR_BLTU;
                    3'b111:  br_type = BR_BGEU;
                    default: dec_bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                mem_to_reg = 1'b1;
                reg_read   = 2'b10;
                alu_ctrl   = ALU_ADD;
                alu_src2   = SRC2_IMM;
                imm_type   = IMM_I;
                case (Fn3)
                    3'b000:  reg_write = RW_LB;
                    3'b001:  reg_write = RW_LH;
                    3'b010:  reg_write = RW_LW;
                    3'b100:  reg_write = RW_LBU;
                    3'b101:  reg_write = RW_LHU;
                    default: dec_bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                reg_read = 2'b11;
                alu_ctrl = ALU_ADD;
                alu_src2 = SRC2_IMM;
                imm_type = IMM_S;
                case (Fn3)
                    3'b000:  mem_write = 4'b0001;
                    3'b001:  mem_write = 4'b0011;
                    3'b010:  mem_write = 4'b1111;
                    default: dec_bad = 1'b1;
                endcase
            end
            OPC_IMM: begin
                reg_write = RW_LW;
                reg_read  = 2'b10;
                alu_src2  = SRC2_IMM;
                imm_type  = IMM_I;
                case (Fn3)
                    3'b000: alu_ctrl = ALU_ADD;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLTU;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b110: alu_ctrl = ALU_OR;
                    3'b111: alu_ctrl = ALU_AND;
                    3'b001: begin
                        alu_ctrl = ALU_SLL;
                        alu_src2 = SRC2_SHAMT;
                        dec_bad  = (Fn7 != F7_BASE);
                    end
                    default: begin
                        alu_src2 = SRC2_SHAMT;
                        if (Fn7 == F7_BASE)     alu_ctrl = ALU_SRL;
                        else if (Fn7 == F7_ALT) alu_ctrl = ALU_SRA;
                        else                    dec_bad  = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                reg_write = RW_LW;
                reg_read  = 2'b11;
                if (Fn7 == F7_M) begin
                    alu_ctrl = ALU_ADD;
                    dec_md   = EN_M;
                    dec_bad  = !EN_M;
                end else if (Fn7 == F7_BASE) begin
                    case (Fn3)
                        3'b000:  alu_ctrl = ALU_ADD;
                        3'b001:  alu_ctrl = ALU_SLL;
                        3'b010:  alu_ctrl = ALU_SLT;
                        3'b011:  alu_ctrl = ALU_SLTU;
                        3'b100:  alu_ctrl = ALU_XOR;
                        3'b101:  alu_ctrl = ALU_SRL;
                        3'b110:  alu_ctrl = ALU_OR;
                        default: alu_ctrl = ALU_AND;
                    endcase
                end else if (Fn7 == F7_ALT && Fn3 == 3'b000) begin
                    alu_ctrl = ALU_SUB;
                end else if (Fn7 == F7_ALT && Fn3 == 3'b101) begin
                    alu_ctrl = ALU_SRA;
                end else begin
                    dec_bad = 1'b1;
                end
            end
            default: dec_bad = 1'b1;
        endcase
    end

    assign dec_ctrl = {jal, jalr, reg_write, mem_to_reg, mem_write, load_npc,
                       reg_read, br_type, alu_ctrl, alu_src1, alu_src2, imm_type};
    assign IllegalD = ValidD & dec_bad;
    assign cnt_load = Fn3[2] ? DIV_LOAD : MUL_LOAD;

    // EX register and M sequencer: reset > flush > hold > load > bubble
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST || FlushE) begin
            CtrlE <= '0;
            MdOpE <= '0;
            state <= S_IDLE;
            cnt   <= '0;
        end else if (StallE || MdBusy) begin
            // the M unit keeps counting even while EX is held
            if (state == S_RUN) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state <= S_DONE;
            end
        end else if (ValidD && !dec_bad) begin
            CtrlE <= dec_ctrl;
            if (dec_md) begin
                cnt   <= cnt_load;
                state <= (cnt_load == '0) ? S_DONE : S_RUN;
                MdOpE <= Fn3;
            end else begin
                cnt   <= '0;
                state <= S_IDLE;
                MdOpE <= '0;
            end
        end else begin
            CtrlE <= '0;
            MdOpE <= '0;
            state <= S_IDLE;
            cnt   <= '0;
        end
    end

    assign MdBusy   = state[0];
    assign MdDoneE  = state[1];
    assign MdValidE = state[0] | state[1];

endmodule

// File: doc/ctrl_decode_md.md
# ctrl_decode_md

Registered ID→EX instruction decoder for the RISC-V pipeline core. It decodes RV32I and, optionally, RV32M, and registers the control bundle into the EX stage. It runs a multi-cycle sequencer for MUL/DIV/REM, which raises a stall request to the hazard unit until the result is ready. Illegal encodings are flagged and replaced by a bubble, and every output is defined for every opcode.

## Interface
- EN_M, 1, decode RV32M (Op 0110011, Fn7 0000001); 0 → those encodings are illegal
- MUL_CYCLES, 2, EX occupancy of MUL/MULH/MULHSU/MULHU, ≥1
- DIV_CYCLES, 33, EX occupancy of DIV/DIVU/REM/REMU, ≥1
- CNT_W, 6, counter width; 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES)
- CPU_CLK  in  1  clock, rising edge
- CPU_RST  in  1  reset, synchronous, active-high
- Op  in  7  ID instruction opcode
- Fn3  in  3  ID funct3
- Fn7  in  7  ID funct7
- ValidD  in  1  ID holds a valid instruction
- StallE  in  1  hazard unit holds EX register
- FlushE  in  1  hazard unit inserts bubble into EX
- CtrlE  out  26  registered bundle, MSB→LSB:
  - [25] Jal, [24] Jalr, [23:21] RegWrite, [20] MemToReg
  - [19:16] MemWrite, [15] LoadNpc, [14:13] RegRead, [12:10] BranchType
  - [9:6] AluContrl, [5] AluSrc1, [4:3] AluSrc2, [2:0] ImmType
  - encodings per Parameters.v
- MdValidE  out  1  EX holds an M instruction
- MdOpE  out  3  funct3 of EX M instruction; 0 when !MdValidE
- MdBusy  out  1  stall request: M op in EX, result not ready
- MdDoneE  out  1  M op in EX, result ready this cycle
- IllegalD  out  1  combinational: ValidD and encoding not legal

## Operation
- **Decode (combinational, ID):**
  - RV32I mapping for LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP, per Parameters.v.
  - Unlisted Op, or unlisted Fn3 for LOAD/STORE/BRANCH → IllegalD.
- **Fn7 legality:**
  - OP: Fn7 ∈ {0000000; 0100000 only with Fn3 000/101; 0000001 only if EN_M}.
  - OP-IMM Fn3 001: Fn7 = 0000000. OP-IMM Fn3 101: Fn7 ∈ {0000000, 0100000}.
  - Anything else → illegal.
- **M decode:** RegWrite=LW, RegRead=11, AluSrc1=0, AluSrc2=00, AluContrl=ADD, ImmType=RTYPE, Md flag=1.
- **EX register update, priority order:**
  1. CPU_RST → all zero.
  2. FlushE → zero (bubble).
  3. StallE | MdBusy → hold.
  4. ValidD & !IllegalD → load decode.
  5. Otherwise → zero.
- **Bubble value:** all zero. This equals NOREGWRITE / NOBRANCH / MemWrite 0000.
- **Sequencer FSM states:**
  - IDLE: no M op in EX.
  - RUN: counting, MdBusy=1.
  - DONE: cnt==0, MdDoneE=1, waiting for EX to advance.
- **Loading an M op into EX:**
  - cnt ← (Fn3[2] ? DIV_CYCLES : MUL_CYCLES) − 1.
  - Next state is RUN, or DONE if the loaded value is 0.
- **RUN:** cnt decrements every cycle, regardless of StallE. At cnt==1 the next state is DONE.
- **DONE, EX advances (no StallE, no FlushE):**
  - New M op loaded → reload cnt, enter RUN/DONE (back-to-back).
  - Non-M op or bubble → IDLE.
- **DONE with StallE:** hold DONE; MdDoneE stays high.
- **FlushE in any state:** IDLE, cnt ← 0. The in-flight M op is abandoned.
- **Derived outputs:**
  - MdBusy = (state==RUN).
  - MdDoneE = (state==DONE).
  - MdValidE = (state≠IDLE).

## Timing
- **Reset values:** CtrlE=0, MdValidE=0, MdOpE=0, MdBusy=0, MdDoneE=0, state=IDLE, cnt=0.
- **IllegalD** is combinational, valid in the same cycle as Op/Fn3/Fn7/ValidD.
- **Control latency:** 1 cycle. ID fields at edge k appear on CtrlE after edge k.
- **M op, no external stall:**
  - Occupies EX for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES).
  - MdBusy is high for the first N−1 of them; MdDoneE is high on the Nth.
- **N=1:** MdDoneE is high on the first EX cycle, MdBusy is never asserted, no stall.
- **MdBusy** depends only on registered state. There is no combinational path from inputs.
- **Simultaneous events:**
  - FlushE with StallE → FlushE wins.
  - CPU_RST beats all.
  - Reset mid-sequence → IDLE on the next edge.

## Test plan
- **Reset:** assert CPU_RST for 2 cycles with Op=0110011 (ADD) presented → CtrlE=0, MdBusy=0; first post-reset edge loads ADD, giving RegWrite=LW, AluContrl=ADD, RegRead=11.
- **DIV sequence:** defaults, DIV (Op 0110011, Fn7 0000001, Fn3 100) enters EX → MdBusy high 32 cycles, MdDoneE high cycle 33, MdOpE=100, then IDLE. Next instruction loads on the edge after cycle 33.
- **Back-to-back:** MUL then MULH with MUL_CYCLES=2 → pattern MdBusy 1,0,1,0 and MdDoneE 0,1,0,1; no IDLE cycle between them.
- **Flush/stall interplay:** FlushE at DIV cycle 10 → next cycle CtrlE=0, MdBusy=0, state IDLE. Separately, StallE held 3 cycles in DONE → MdDoneE stays 1 for 4 cycles.
- **Illegality:**
  - EN_M=0 with MUL encoding → IllegalD=1, EX loads bubble.
  - Op 1111111 → IllegalD=1.
  - SLLI with Fn7 0100000 → IllegalD=1.
  - SRAI with Fn7 0100000 → legal, AluContrl=SRA.
- **Flush precedence:** StallE=1 with MdBusy=1 and FlushE=1 simultaneously → flush wins, bubble loaded, MdBusy=0 next cycle.
